// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : unified_mem_arbiter_pkg                                  |
// | Purpose : shared encodings and default widths for the arbiter      |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
package unified_mem_arbiter_pkg;

  localparam int c_addr_width   = 8;
  localparam int c_data_width   = 16;
  localparam int c_starve_limit = 4;
  localparam int c_cnt_width    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_owner_t;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_starve_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : arb_starve_ctr                                           |
// | Purpose : saturating count of data grants taken while a fetch waits|
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
module arb_starve_ctr
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = c_starve_limit
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != c_limit)) begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  assign o_at_limit = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : unified_mem_arbiter                                      |
// | Purpose : fetch/data arbiter for one shared single-port memory     |
// | Options : ARB_PERF_CNT_EN adds saturating performance counters     |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = c_addr_width,
  parameter int DATA_WIDTH   = c_data_width,
  parameter int STARVE_LIMIT = c_starve_limit,
  parameter int CNT_WIDTH    = c_cnt_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_valid,
  output logic                  if_stall,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  output logic                  mem_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0]  perf_i_stall,
  output logic [CNT_WIDTH-1:0]  perf_d_stall,
  output logic [CNT_WIDTH-1:0]  perf_starve,
`endif
  output logic                  arb_err
);

  if (STARVE_LIMIT < 1) begin : g_chk_starve_limit
    $error("STARVE_LIMIT must be at least 1");
  end
  if (CNT_WIDTH < 1) begin : g_chk_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  gnt_owner_t            w_gnt;
  logic                  w_i_elig;
  logic                  w_d_rd_elig;
  logic                  w_d_elig;
  logic                  w_at_limit;
  logic                  w_rd;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] r_addr_last;

  // A port whose read is in flight or returning this cycle may not be re-granted.
  assign w_i_elig    = i_req & (r_state != RD_I) & ~i_valid;
  assign w_d_rd_elig = d_rd & (r_state != RD_D) & ~d_valid;
  assign w_d_elig    = d_wr | w_d_rd_elig;

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_i_elig && (!w_d_elig || w_at_limit)) begin
      w_gnt = GNT_I;
    end else if (w_d_elig) begin
      w_gnt = GNT_D;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    mem_addr    = r_addr_last;
    case (w_gnt)
      GNT_I: begin
        w_rd        = 1'b1;
        mem_addr    = i_addr;
        w_state_nxt = RD_I;
      end
      GNT_D: begin
        mem_addr = d_addr;
        if (d_wr) begin
          w_wr = 1'b1;
        end else begin
          w_rd        = 1'b1;
          w_state_nxt = RD_D;
        end
      end
      default: ;
    endcase
  end

  assign mem_rd    = w_rd & rst;
  assign mem_wr    = w_wr & rst;
  assign mem_wdata = d_wdata;
  assign d_gnt     = (w_gnt == GNT_D) & rst;
  assign if_stall  = i_req & ~i_valid;
  assign mem_stall = (d_rd & ~d_valid) | (d_wr & ~d_gnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr_last <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      arb_err     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr_last <= mem_addr;
      i_valid     <= (r_state == RD_I);
      d_valid     <= (r_state == RD_D);
      if (r_state == RD_I) i_rdata <= mem_rdata;
      if (r_state == RD_D) d_rdata <= mem_rdata;
      if (d_rd && d_wr) arb_err <= 1'b1;
    end
  end

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (~i_req | (w_gnt == GNT_I)),
    .i_inc      ((w_gnt == GNT_D) & w_i_elig),
    .o_at_limit (w_at_limit)
  );

`ifdef ARB_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  // A fetch grant is forced only when data also wanted the slot.
  logic w_forced;
  assign w_forced = (w_gnt == GNT_I) & w_d_elig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_i_stall <= '0;
      perf_d_stall <= '0;
      perf_starve  <= '0;
    end else begin
      if (if_stall && (perf_i_stall != c_cnt_max)) perf_i_stall <= perf_i_stall + CNT_WIDTH'(1);
      if (mem_stall && (perf_d_stall != c_cnt_max)) perf_d_stall <= perf_d_stall + CNT_WIDTH'(1);
      if (w_forced && (perf_starve != c_cnt_max)) perf_starve <= perf_starve + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_unified_mem_arbiter                                   |
// | Purpose : randomized + directed bench with a cycle-stamped model   |
// | Rev     : 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_unified_mem_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LIMIT = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          if_stall;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_stall;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          arb_err;
`ifdef ARB_PERF_CNT_EN
  logic [CW-1:0] perf_i_stall, perf_d_stall, perf_starve;
`endif

  unified_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .if_stall(if_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rdata(d_rdata), .d_valid(d_valid), .mem_stall(mem_stall),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef ARB_PERF_CNT_EN
    .perf_i_stall(perf_i_stall), .perf_d_stall(perf_d_stall), .perf_starve(perf_starve),
`endif
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_wr) ram[mem_addr] = mem_wdata;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: reads are tracked by the cycle their valid is due.
  logic [DW-1:0] ref_mem [256];
  int            m_i_ret, m_d_ret, m_starve, m_pi, m_pd, m_ps;
  logic [DW-1:0] m_i_word, m_d_word, m_i_rdata, m_d_rdata;
  logic          m_err;
  logic [AW-1:0] m_last_addr;
  logic          x_iv, x_dv, x_gd;
  logic          s_dgnt, s_mrd;

  task automatic model_check();
    logic iel, del, gi, gd, erd, ewr, eiv, edv, eis, ems;
    logic [AW-1:0] eaddr;
    if (!rst) begin
      m_i_ret = -10; m_d_ret = -10; m_starve = 0; m_err = 1'b0; m_last_addr = '0;
      m_i_rdata = '0; m_d_rdata = '0; m_pi = 0; m_pd = 0; m_ps = 0;
    end
    eiv = rst && (cyc == m_i_ret);
    edv = rst && (cyc == m_d_ret);
    if (eiv) m_i_rdata = m_i_word;
    if (edv) m_d_rdata = m_d_word;
    iel   = i_req && (cyc > m_i_ret);
    del   = d_wr || (d_rd && (cyc > m_d_ret));
    gi    = rst && iel && (!del || m_starve == LIMIT);
    gd    = rst && !gi && del;
    erd   = gi || (gd && !d_wr);
    ewr   = gd && d_wr;
    eaddr = gi ? i_addr : (gd ? d_addr : m_last_addr);
    eis   = i_req && !eiv;
    ems   = (d_rd && !edv) || (d_wr && !gd);

    check_val("mem_rd", mem_rd, erd);
    check_val("mem_wr", mem_wr, ewr);
    check_val("mem_addr", mem_addr, eaddr);
    if (ewr) check_val("mem_wdata", mem_wdata, d_wdata);
    check_val("d_gnt", d_gnt, gd);
    check_val("i_valid", i_valid, eiv);
    check_val("d_valid", d_valid, edv);
    check_val("i_rdata", i_rdata, m_i_rdata);
    check_val("d_rdata", d_rdata, m_d_rdata);
    check_val("if_stall", if_stall, eis);
    check_val("mem_stall", mem_stall, ems);
    check_val("arb_err", arb_err, m_err);
`ifdef ARB_PERF_CNT_EN
    check_val("perf_i_stall", perf_i_stall, m_pi);
    check_val("perf_d_stall", perf_d_stall, m_pd);
    check_val("perf_starve", perf_starve, m_ps);
`endif
    x_iv = eiv; x_dv = edv; x_gd = gd;
    s_dgnt = d_gnt; s_mrd = mem_rd;

    if (rst) begin
      if (gi) begin m_i_ret = cyc + 2; m_i_word = ref_mem[i_addr]; end
      if (gd && !d_wr) begin m_d_ret = cyc + 2; m_d_word = ref_mem[d_addr]; end
      if (ewr) ref_mem[d_addr] = d_wdata;
      m_last_addr = eaddr;
      if (!i_req || gi) m_starve = 0;
      else if (gd && iel && m_starve < LIMIT) m_starve++;
      if (d_rd && d_wr) m_err = 1'b1;
      if (eis && m_pi < 65535) m_pi++;
      if (ems && m_pd < 65535) m_pd++;
      if (gi && del && m_ps < 65535) m_ps++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Requesters release a request after its completion cycle.
  task automatic retire_reqs();
    if (i_req && x_iv) i_req = 1'b0;
    if ((d_rd && x_dv) || (d_wr && x_gd)) begin d_rd = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic drain();
    int n = 0;
    while ((i_req || d_rd || d_wr) && n < 20) begin
      tick();
      retire_reqs();
      n++;
    end
    check_val("drain_idle", {31'b0, i_req | d_rd | d_wr}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_dg;
    logic seen_f;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'($urandom);
    end
    ram[8'h10] = 16'h1234;
    ram[8'h01] = 16'h1111;
    ram[8'h02] = 16'h2222;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
    x_iv = 1'b0; x_dv = 1'b0; x_gd = 1'b0;

    #1;
    tick(); tick();
    rst = 1'b1;
    tick();

    // fetch only
    i_req = 1'b1; i_addr = 8'h10;
    drain();
    check_val("fetch_word", i_rdata, 16'h1234);

    // fetch and data write collide; read back the written word
    i_req = 1'b1; i_addr = 8'h00;
    d_wr = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
    drain();
    d_rd = 1'b1; d_addr = 8'h20;
    drain();
    check_val("conflict_readback", d_rdata, 16'hBEEF);

    // starvation: back-to-back data writes against a waiting fetch
    i_req = 1'b1; i_addr = 8'h10;
    d_wr = 1'b1; d_addr = 8'h40; d_wdata = 16'hC000;
    n_dg = 0; seen_f = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (s_mrd) begin seen_f = 1'b1; break; end
      if (s_dgnt) n_dg++;
      if (x_gd) begin d_addr = d_addr + 8'd1; d_wdata = d_wdata + 16'd1; end
    end
    check_val("starve_dgrants", n_dg, 32'd4);
    check_val("starve_fetch", {31'b0, seen_f}, 32'd1);
    drain();
`ifdef ARB_PERF_CNT_EN
    check_val("starve_perf", perf_starve, 32'd1);
`endif

    // back-to-back reads
    d_rd = 1'b1; d_addr = 8'h01;
    tick();
    i_req = 1'b1; i_addr = 8'h02;
    drain();
    check_val("b2b_d_word", d_rdata, 16'h1111);
    check_val("b2b_i_word", i_rdata, 16'h2222);

    // reset while a fetch is in flight
    i_req = 1'b1; i_addr = 8'h10;
    tick();
    rst = 1'b0; i_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick(); tick();
    check_val("rst_i_rdata", i_rdata, 32'd0);

    // randomized traffic
    repeat (400) begin
      retire_reqs();
      if (!i_req && $urandom_range(0, 99) < 55) begin
        i_req = 1'b1; i_addr = 8'($urandom_range(0, 15));
      end
      if (!d_rd && !d_wr && $urandom_range(0, 99) < 55) begin
        if ($urandom_range(0, 1) == 1) d_wr = 1'b1; else d_rd = 1'b1;
        d_addr = 8'($urandom_range(0, 15)); d_wdata = 16'($urandom);
      end
      tick();
    end
    drain();

    // illegal simultaneous read and write
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 8'h30; d_wdata = 16'h0F0F;
    drain();
    tick(); tick(); tick();
    check_val("err_sticky", arb_err, 32'd1);
    d_rd = 1'b1; d_addr = 8'h30;
    drain();
    check_val("illegal_write", d_rdata, 16'h0F0F);
    check_val("err_still", arb_err, 32'd1);
    rst = 1'b0;
    tick();
    check_val("err_cleared", arb_err, 32'd0);
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
